// File: rtl/aes_inv_key_schedule.sv
// AES-128 round-key source for decryption. The forward schedule runs once up to
// the round-10 key, then keys are regenerated in reverse order (10..0) without a key store.
module aes_inv_key_schedule #(
    parameter int NB = 4,
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:127] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk_out,
    output logic [3:0]   rk_round,
    output logic         done
);

    if (NB != 4 || NK != 4 || NR != 10) begin : g_bad_params
        $error("aes_inv_key_schedule supports only NB=4, NK=4, NR=10");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        SERVE  = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // SubWord(RotWord(x)): rotate left by one byte, then substitute each byte
    function automatic logic [31:0] sub_rot(input logic [31:0] x);
        return {SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]], SBOX[x[31:24]]};
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return {c, 24'h000000};
    endfunction

    state_t      state, state_nxt;
    logic [31:0] w [4];
    logic [31:0] w_nxt [4];
    logic [3:0]  round_nxt;
    logic        done_nxt;

    logic [31:0] fwd_t, f0, f1, f2, f3;
    logic [31:0] v0, v1, v2, v3;

    assign fwd_t = sub_rot(w[3]) ^ rcon(rk_round + 4'd1);
    assign f0    = w[0] ^ fwd_t;
    assign f1    = w[1] ^ f0;
    assign f2    = w[2] ^ f1;
    assign f3    = w[3] ^ f2;

    // Inverse step undoes the forward step that produced round rk_round
    assign v3 = w[3] ^ w[2];
    assign v2 = w[2] ^ w[1];
    assign v1 = w[1] ^ w[0];
    assign v0 = w[0] ^ sub_rot(v3) ^ rcon(rk_round);

    assign busy     = (state == EXPAND);
    assign rk_valid = (state == SERVE);
    assign rk_out   = {w[0], w[1], w[2], w[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        round_nxt = rk_round;
        done_nxt  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_nxt[i] = w[i];
        end
        // A new key restarts the sequence from any state, overriding handshakes
        if (key_load) begin
            state_nxt = EXPAND;
            round_nxt = 4'd0;
            w_nxt[0]  = key_in[0:31];
            w_nxt[1]  = key_in[32:63];
            w_nxt[2]  = key_in[64:95];
            w_nxt[3]  = key_in[96:127];
        end else begin
            case (state)
                EXPAND: begin
                    w_nxt[0]  = f0;
                    w_nxt[1]  = f1;
                    w_nxt[2]  = f2;
                    w_nxt[3]  = f3;
                    round_nxt = rk_round + 4'd1;
                    if (rk_round == 4'd9) begin
                        state_nxt = SERVE;
                    end
                end
                SERVE: begin
                    if (rk_ready) begin
                        if (rk_round != 4'd0) begin
                            w_nxt[0]  = v0;
                            w_nxt[1]  = v1;
                            w_nxt[2]  = v2;
                            w_nxt[3]  = v3;
                            round_nxt = rk_round - 4'd1;
                        end else begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                w[i] <= '0;
            end
            rk_round <= '0;
            done     <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                w[i] <= w_nxt[i];
            end
            rk_round <= round_nxt;
            done     <= done_nxt;
        end
    end

endmodule
